// File: rtl/cheat_code_loader.sv
// cheat_code_loader: packs the HPS cheat download byte stream into 128-bit
// {flags, address, compare, replace} records and sends each one on the 129-bit
// cheat code bus. Every record gets one full low->high->low cycle of code[128].
module cheat_code_loader #(
  parameter logic [7:0]  CHEAT_INDEX  = 8'd255,
  parameter int unsigned MAX_CODES    = 32,
  parameter int unsigned PULSE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ioctl_download,
  input  logic [7:0]   ioctl_index,
  input  logic         ioctl_wr,
  input  logic [7:0]   ioctl_dout,
  output logic         ioctl_wait,
  output logic         cheat_reset,
  output logic [128:0] code,
  output logic [7:0]   code_count,
  output logic         busy,
  output logic         overflow_err,
  output logic         partial_err
);

  localparam int unsigned PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_CYCLES - 1);
  localparam int unsigned BW  = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned RW  = 128;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HI   = 2'd2,
    S_LO   = 2'd3
  } state_t;

  // Registered state
  state_t          r_state;
  logic [PCW-1:0]  r_pcnt;
  logic            r_active_q;
  logic            r_cheat_reset;
  logic [BW-1:0]   r_b;
  logic            r_pending;
  logic [RW-1:0]   r_rec;
  logic [RW:0]     r_code;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic            r_part;
  logic            r_busy;

  // Combinational next values
  logic            w_active;
  logic            w_rise;
  logic            w_fall;
  logic            w_byte;
  logic [BW-1:0]   w_b_eff;
  logic [CW-1:0]   w_count_eff;
  logic [6:0]      w_lane;
  state_t          w_state_nxt;
  logic [PCW-1:0]  w_pcnt_nxt;
  logic            w_load;
  logic            w_abort;
  logic            w_clk_bit_nxt;
  logic [BW-1:0]   w_b_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic            w_ovf_nxt;
  logic            w_part_nxt;
  logic            w_rec_we;
  logic            w_pend_set;
  logic            w_pending_nxt;

  // Download qualification and edge detection of the active window
  assign w_active = ioctl_download && (ioctl_index == CHEAT_INDEX);
  assign w_rise   = w_active && !r_active_q;
  assign w_fall   = !w_active && r_active_q;
  assign w_byte   = w_active && ioctl_wr;

  // A download start restarts assembly, so a byte on that cycle sees b=0
  assign w_b_eff     = w_rise ? '0 : r_b;
  assign w_count_eff = w_rise ? '0 : r_count;

  // Bit offset of the current byte: field 0 lands in the top word, lane 0 in the low byte
  assign w_lane = {~w_b_eff[3:2], w_b_eff[1:0], 3'b000};

  // Transmit FSM next state, pulse counter and clock-bit value
  always_comb begin
    w_state_nxt   = r_state;
    w_pcnt_nxt    = r_pcnt;
    w_load        = 1'b0;
    w_abort       = r_cheat_reset && ((r_state == S_HI) || (r_state == S_LO));
    w_clk_bit_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = S_HI;
        w_pcnt_nxt  = '0;
      end
      S_HI: begin
        if (r_pcnt == PULSE_LAST) begin
          w_state_nxt = S_LO;
          w_pcnt_nxt  = '0;
        end else begin
          w_pcnt_nxt = r_pcnt + PCW'(1);
        end
      end
      S_LO: begin
        if (r_pcnt == PULSE_LAST) begin
          w_state_nxt = S_IDLE;
          w_pcnt_nxt  = '0;
        end else begin
          w_pcnt_nxt = r_pcnt + PCW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pcnt_nxt  = '0;
      end
    endcase
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_pcnt_nxt  = '0;
    end
    // code[128] trails the HI state by one register stage
    w_clk_bit_nxt = (r_state == S_HI) && !w_abort;
  end

  // Byte assembly, record completion and error flag next values
  always_comb begin
    w_b_nxt     = w_b_eff;
    w_count_nxt = w_count_eff;
    w_ovf_nxt   = w_rise ? 1'b0 : r_ovf;
    w_part_nxt  = w_rise ? 1'b0 : r_part;
    w_rec_we    = 1'b0;
    w_pend_set  = 1'b0;
    if (w_fall && (r_b != '0)) begin
      w_part_nxt = 1'b1;
      w_b_nxt    = '0;
    end
    if (w_byte) begin
      if (r_pending) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_rec_we = 1'b1;
        if (w_b_eff == BW'(15)) begin
          w_b_nxt = '0;
          if (32'(w_count_eff) < MAX_CODES) begin
            w_pend_set = 1'b1;
          end
          if (w_count_eff != CW'(255)) begin
            w_count_nxt = w_count_eff + CW'(1);
          end
        end else begin
          w_b_nxt = w_b_eff + BW'(1);
        end
      end
    end
  end

  // Pending record flag: set on completion, freed by LOAD or an abort
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_load || w_abort) begin
      w_pending_nxt = 1'b0;
    end
    if (w_pend_set) begin
      w_pending_nxt = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
    end
  end

  // Download tracking, assembly counters and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active_q    <= 1'b0;
      r_cheat_reset <= 1'b0;
      r_b           <= '0;
      r_pending     <= 1'b0;
      r_count       <= '0;
      r_ovf         <= 1'b0;
      r_part        <= 1'b0;
    end else begin
      r_active_q    <= w_active;
      r_cheat_reset <= w_rise;
      r_b           <= w_b_nxt;
      r_pending     <= w_pending_nxt;
      r_count       <= w_count_nxt;
      r_ovf         <= w_ovf_nxt;
      r_part        <= w_part_nxt;
    end
  end

  // Record buffer byte writes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rec <= '0;
    end else if (w_rec_we) begin
      r_rec[w_lane +: 8] <= ioctl_dout;
    end
  end

  // Output bus: payload captured in LOAD, clock bit driven from the FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_code <= '0;
    end else begin
      if (w_load) begin
        r_code[RW-1:0] <= r_rec;
      end
      r_code[RW] <= w_clk_bit_nxt;
    end
  end

  // Back-pressure / busy: high while a record waits or the FSM is active
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= w_pending_nxt || (w_state_nxt != S_IDLE);
    end
  end

  assign ioctl_wait   = r_busy;
  assign busy         = r_busy;
  assign cheat_reset  = r_cheat_reset;
  assign code         = r_code;
  assign code_count   = r_count;
  assign overflow_err = r_ovf;
  assign partial_err  = r_part;

endmodule

// File: tb/tb_cheat_code_loader.sv
// tb_cheat_code_loader: directed bench for the cheat code loader.
module tb_cheat_code_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         ioctl_download;
  logic [7:0]   ioctl_index;
  logic         ioctl_wr;
  logic [7:0]   ioctl_dout;
  logic         ioctl_wait;
  logic         cheat_reset;
  logic [128:0] code;
  logic [7:0]   code_count;
  logic         busy;
  logic         overflow_err;
  logic         partial_err;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;
  int edges_snap;
  logic prev_bit = 1'b0;

  logic [7:0] v1 [16] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 8'h00, 8'h00,
                          8'hAA, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;

  cheat_code_loader dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .cheat_reset    (cheat_reset),
    .code           (code),
    .code_count     (code_count),
    .busy           (busy),
    .overflow_err   (overflow_err),
    .partial_err    (partial_err)
  );

  // Count rising edges of the bus clock bit, sampled mid-cycle
  always @(negedge clk) begin
    if (code[128] && !prev_bit) edges = edges + 1;
    prev_bit = code[128];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_dout = d;
    step();
    ioctl_wr   = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] base);
    for (int j = 0; j < 16; j++) send_byte(base + 8'(j));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 64 && ioctl_wait; i++) step();
    chk(tag, 129'(ioctl_wait), 129'(0));
  endtask

  task automatic restart_download();
    ioctl_download = 1'b0;
    step();
    ioctl_download = 1'b1;
    step();
  endtask

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd255;
    ioctl_wr       = 1'b0;
    ioctl_dout     = 8'h00;
    step();
    step();
    chk("rst_code",  code, 129'(0));
    chk("rst_wait",  129'(ioctl_wait), 129'(0));
    chk("rst_creset", 129'(cheat_reset), 129'(0));
    chk("rst_count", 129'(code_count), 129'(0));
    chk("rst_busy",  129'(busy), 129'(0));
    chk("rst_ovf",   129'(overflow_err), 129'(0));
    chk("rst_part",  129'(partial_err), 129'(0));

    // Download start: one-cycle clear pulse
    reset          = 1'b0;
    ioctl_download = 1'b1;
    step();
    chk("start_creset_hi", 129'(cheat_reset), 129'(1));
    step();
    chk("start_creset_lo", 129'(cheat_reset), 129'(0));
    chk("start_count", 129'(code_count), 129'(0));

    // Basic record with exact clock-bit timing
    for (int j = 0; j < 16; j++) send_byte(v1[j]);
    chk("rec1_wait_T", 129'(ioctl_wait), 129'(1));
    chk("rec1_count", 129'(code_count), 129'(1));
    step();
    chk("rec1_bit_T1", 129'(code[128]), 129'(0));
    step();
    chk("rec1_code_T2", code, {1'b0, 128'h00000001_00001234_000000AA_00000055});
    step();
    chk("rec1_bit_T3", 129'(code[128]), 129'(1));
    step();
    chk("rec1_bit_T4", 129'(code[128]), 129'(1));
    step();
    chk("rec1_bit_T5", 129'(code[128]), 129'(0));
    step();
    chk("rec1_bit_T6", 129'(code[128]), 129'(0));
    chk("rec1_wait_T6", 129'(ioctl_wait), 129'(0));
    chk("rec1_hold", code, {1'b0, 128'h00000001_00001234_000000AA_00000055});

    // Stream ignoring back-pressure: 17th byte while record pending
    send_seq(8'h10);
    send_byte(8'hEE);
    chk("ovf_flag", 129'(overflow_err), 129'(1));
    step();
    chk("ovf_code", code, {1'b0, 128'h13121110_17161514_1B1A1918_1F1E1D1C});
    step();
    chk("ovf_bit", 129'(code[128]), 129'(1));
    wait_idle("ovf_wait_timeout");
    chk("ovf_count", 129'(code_count), 129'(2));
    chk("ovf_intact", code, {1'b0, 128'h13121110_17161514_1B1A1918_1F1E1D1C});

    // Fresh download clears flags; download cut short after 20 bytes
    restart_download();
    chk("p_creset", 129'(cheat_reset), 129'(1));
    chk("p_ovf_clr", 129'(overflow_err), 129'(0));
    chk("p_count_clr", 129'(code_count), 129'(0));
    step();
    send_seq(8'h20);
    wait_idle("p_wait_timeout");
    for (int j = 0; j < 4; j++) send_byte(8'h30 + 8'(j));
    ioctl_download = 1'b0;
    step();
    chk("p_part", 129'(partial_err), 129'(1));
    chk("p_count", 129'(code_count), 129'(1));
    chk("p_code", code, {1'b0, 128'h23222120_27262524_2B2A2928_2F2E2D2C});
    ioctl_download = 1'b1;
    step();
    chk("p_part_clr", 129'(partial_err), 129'(0));
    step();
    send_seq(8'h40);
    wait_idle("p2_wait_timeout");
    chk("p2_code", code, {1'b0, 128'h43424140_47464544_4B4A4948_4F4E4D4C});
    chk("p2_count", 129'(code_count), 129'(1));

    // 40 records, only the first 32 transmitted
    restart_download();
    step();
    edges_snap = edges;
    for (int r = 0; r < 40; r++) begin
      send_seq(8'(r * 16));
      wait_idle("max_wait_timeout");
    end
    step();
    step();
    chk("max_edges", 129'(edges - edges_snap), 129'(32));
    chk("max_count", 129'(code_count), 129'(40));
    chk("max_ovf", 129'(overflow_err), 129'(0));
    chk("max_last_code", code, {1'b0, 128'hF3F2F1F0_F7F6F5F4_FBFAF9F8_FFFEFDFC});

    // Reset while the clock bit is high
    restart_download();
    step();
    send_seq(8'h50);
    for (int i = 0; i < 10 && !code[128]; i++) step();
    chk("rhi_bit_seen", 129'(code[128]), 129'(1));
    reset = 1'b1;
    step();
    chk("rhi_code", code, 129'(0));
    chk("rhi_wait", 129'(ioctl_wait), 129'(0));
    edges_snap = edges;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("rhi_no_edges", 129'(edges - edges_snap), 129'(0));
    chk("rhi_bit_low", 129'(code[128]), 129'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
